// File: rtl/dma_term_pkg.sv
// Shared definitions for the DMA transfer-termination unit: mode codes, FSM encoding
// and the default datapath width.
package dma_term_pkg;

    localparam int NBITS_DEF = 8;

    localparam logic [1:0] MODE_DOWN = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_ADDR = 2'b10;
    localparam logic [1:0] MODE_FREE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TERM = 2'b10
    } state_t;

endpackage

// File: rtl/dma_term_cmp.sv
// Last-word detector: flags that the next acknowledged word ends the transfer,
// independent of FSM state (the top level gates it with RUN).
module dma_term_cmp
    import dma_term_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] wcount,
    input  logic [NBITS-1:0] wr,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] alim,
    output logic             last
);

    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    logic [NBITS-1:0] wc_inc;

    // Wrap at NBITS so WR=0 in count-up mode means a full 2^NBITS words.
    assign wc_inc = wcount + ONE;

    always_comb begin
        last = 1'b0;
        case (mode)
            MODE_DOWN: last = (wcount == ONE);
            MODE_UP:   last = (wc_inc == wr);
            MODE_ADDR: last = (addr == alim);
            default:   last = 1'b0;
        endcase
    end

endmodule

// File: rtl/dma_xfer_term.sv
// DMA channel transfer-termination unit: address/word counters, configuration
// shadows, IDLE/RUN/TERM control, done pulse and sticky interrupt.
module dma_xfer_term
    import dma_term_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int ASTEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_dir,
    input  logic             cfg_reload,
    input  logic [NBITS-1:0] cfg_wr,
    input  logic [NBITS-1:0] cfg_ac,
    input  logic [NBITS-1:0] cfg_alim,
    input  logic             start,
    input  logic             xfer_ack,
    input  logic             abort,
    input  logic             irq_clr,
    output logic             busy,
    output logic [NBITS-1:0] addr,
    output logic [NBITS-1:0] wcount,
    output logic             last,
    output logic             done,
    output logic             irq,
    output logic [1:0]       state_dbg
);

    localparam logic [NBITS-1:0] STEP = NBITS'(ASTEP);
    localparam logic [NBITS-1:0] ONE  = NBITS'(1);

    state_t           state;
    logic [1:0]       mode_sh;
    logic             dir_sh;
    logic             reload_sh;
    logic [NBITS-1:0] wr_sh;
    logic [NBITS-1:0] ac_sh;
    logic [NBITS-1:0] alim_sh;

    logic             last_word;
    logic [NBITS-1:0] addr_step;
    logic [NBITS-1:0] wcount_step;
    logic [NBITS-1:0] wcount_init;

    dma_term_cmp #(
        .NBITS(NBITS)
    ) u_cmp (
        .mode   (mode_sh),
        .wcount (wcount),
        .wr     (wr_sh),
        .addr   (addr),
        .alim   (alim_sh),
        .last   (last_word)
    );

    assign addr_step   = dir_sh ? (addr - STEP) : (addr + STEP);
    assign wcount_step = (mode_sh == MODE_DOWN) ? (wcount - ONE) : (wcount + ONE);
    assign wcount_init = (mode_sh == MODE_DOWN) ? wr_sh : '0;

    assign busy      = (state != ST_IDLE);
    assign last      = (state == ST_RUN) && last_word;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_sh   <= '0;
            dir_sh    <= 1'b0;
            reload_sh <= 1'b0;
            wr_sh     <= '0;
            ac_sh     <= '0;
            alim_sh   <= '0;
            addr      <= '0;
            wcount    <= '0;
            done      <= 1'b0;
            irq       <= 1'b0;
        end else begin
            done <= 1'b0;

            // The set happens as TERM is left, so a clear during the done cycle loses.
            if (state == ST_TERM && !abort) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        mode_sh   <= cfg_mode;
                        dir_sh    <= cfg_dir;
                        reload_sh <= cfg_reload;
                        wr_sh     <= cfg_wr;
                        ac_sh     <= cfg_ac;
                        alim_sh   <= cfg_alim;
                    end
                    // Start reads the shadows as they were before a coincident cfg_we.
                    if (start) begin
                        addr   <= ac_sh;
                        wcount <= wcount_init;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (xfer_ack) begin
                        addr   <= addr_step;
                        wcount <= wcount_step;
                        if (last_word) begin
                            state <= ST_TERM;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_TERM: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (reload_sh) begin
                        addr   <= ac_sh;
                        wcount <= wcount_init;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_term.sv
// Directed bench for dma_xfer_term: drivers push expected done events into a queue,
// a negedge monitor pops and compares them whenever done is presented.
module tb_dma_xfer_term;
    import dma_term_pkg::*;

    localparam int NB = 8;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_mode;
    logic          cfg_dir;
    logic          cfg_reload;
    logic [NB-1:0] cfg_wr;
    logic [NB-1:0] cfg_ac;
    logic [NB-1:0] cfg_alim;
    logic          start;
    logic          xfer_ack;
    logic          abort;
    logic          irq_clr;
    logic          busy;
    logic [NB-1:0] addr;
    logic [NB-1:0] wcount;
    logic          last;
    logic          done;
    logic          irq;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    dma_xfer_term #(
        .NBITS(NB),
        .ASTEP(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_mode   (cfg_mode),
        .cfg_dir    (cfg_dir),
        .cfg_reload (cfg_reload),
        .cfg_wr     (cfg_wr),
        .cfg_ac     (cfg_ac),
        .cfg_alim   (cfg_alim),
        .start      (start),
        .xfer_ack   (xfer_ack),
        .abort      (abort),
        .irq_clr    (irq_clr),
        .busy       (busy),
        .addr       (addr),
        .wcount     (wcount),
        .last       (last),
        .done       (done),
        .irq        (irq),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the next queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", cyc, {16'b0, mon_e[31:16]});
                check("done_addr", {24'b0, addr}, {24'b0, mon_e[15:8]});
                check("done_wcount", {24'b0, wcount}, {24'b0, mon_e[7:0]});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [1:0] m, input logic d, input logic r,
                             input logic [7:0] wr, input logic [7:0] ac, input logic [7:0] al);
        cfg_mode   = m;
        cfg_dir    = d;
        cfg_reload = r;
        cfg_wr     = wr;
        cfg_ac     = ac;
        cfg_alim   = al;
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic start_xfer();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic expect_done(input int c, input logic [7:0] a, input logic [7:0] w);
        logic [15:0] c16;
        c16 = c[15:0];
        exp_q.push_back({c16, a, w});
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_mode = 2'b00; cfg_dir = 1'b0; cfg_reload = 1'b0;
        cfg_wr = '0; cfg_ac = '0; cfg_alim = '0; start = 1'b0; xfer_ack = 1'b0;
        abort = 1'b0; irq_clr = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_addr", {24'b0, addr}, 0);
        check("rst_wcount", {24'b0, wcount}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_last", {31'b0, last}, 0);
        rst = 1'b0;

        // Count-down, WR=3, ac=0x10
        configure(MODE_DOWN, 1'b0, 1'b0, 8'd3, 8'h10, 8'h00);
        start_xfer();
        check("t1_busy", {31'b0, busy}, 1);
        check("t1_wcount0", {24'b0, wcount}, 3);
        expect_done(cyc + 3, 8'h13, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", {24'b0, addr}, 32'h10 + i);
            check("t1_last", {31'b0, last}, (i == 2) ? 1 : 0);
            xfer_ack = 1'b1;
            tick();
        end
        xfer_ack = 1'b0;
        check("t1_term_busy", {31'b0, busy}, 1);
        tick();
        check("t1_idle_busy", {31'b0, busy}, 0);
        check("t1_irq", {31'b0, irq}, 1);

        // Count-up, WR=0 -> 256 words, decrementing address
        clear_irq();
        check("t2_irq_clr", {31'b0, irq}, 0);
        configure(MODE_UP, 1'b1, 1'b0, 8'd0, 8'h40, 8'h00);
        start_xfer();
        check("t2_addr0", {24'b0, addr}, 32'h40);
        check("t2_wcount0", {24'b0, wcount}, 0);
        expect_done(cyc + 256, 8'h40, 8'h00);
        for (int i = 0; i < 256; i++) begin
            if (i == 254) check("t2_last_early", {31'b0, last}, 0);
            if (i == 255) begin
                check("t2_wcount_ff", {24'b0, wcount}, 32'hff);
                check("t2_last", {31'b0, last}, 1);
            end
            xfer_ack = 1'b1;
            tick();
        end
        xfer_ack = 1'b0;
        tick();
        check("t2_idle_busy", {31'b0, busy}, 0);

        // Address match with wrap: 0xFE -> 0x01
        configure(MODE_ADDR, 1'b0, 1'b0, 8'd0, 8'hfe, 8'h01);
        start_xfer();
        expect_done(cyc + 4, 8'h02, 8'h04);
        for (int i = 0; i < 4; i++) begin
            check("t3_addr", {24'b0, addr}, (32'hfe + i) & 32'hff);
            check("t3_last", {31'b0, last}, (i == 3) ? 1 : 0);
            xfer_ack = 1'b1;
            tick();
        end
        xfer_ack = 1'b0;
        tick();
        check("t3_idle_busy", {31'b0, busy}, 0);

        // Auto-reload with continuous acks; irq_clr on the second done cycle
        clear_irq();
        configure(MODE_DOWN, 1'b0, 1'b1, 8'd4, 8'h20, 8'h00);
        start_xfer();
        c0 = cyc;
        expect_done(c0 + 4, 8'h24, 8'h00);
        expect_done(c0 + 9, 8'h24, 8'h00);
        for (int i = 0; i < 10; i++) begin
            xfer_ack = 1'b1;
            irq_clr  = (i == 9);
            check("t4_busy", {31'b0, busy}, 1);
            tick();
        end
        xfer_ack = 1'b0;
        irq_clr  = 1'b0;
        check("t4_irq_kept", {31'b0, irq}, 1);
        check("t4_reload_addr", {24'b0, addr}, 32'h20);
        check("t4_reload_wcount", {24'b0, wcount}, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", {31'b0, busy}, 0);
        check("t4_abort_addr", {24'b0, addr}, 32'h20);
        check("t4_abort_irq", {31'b0, irq}, 1);

        // Reset mid-transfer, then start with zeroed shadows
        configure(MODE_UP, 1'b0, 1'b0, 8'd5, 8'h30, 8'h00);
        start_xfer();
        xfer_ack = 1'b1;
        tick();
        tick();
        xfer_ack = 1'b0;
        check("t6_wcount2", {24'b0, wcount}, 2);
        rst = 1'b1;
        tick();
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_addr", {24'b0, addr}, 0);
        check("t6_wcount", {24'b0, wcount}, 0);
        check("t6_done", {31'b0, done}, 0);
        check("t6_irq", {31'b0, irq}, 0);
        check("t6_last", {31'b0, last}, 0);
        rst = 1'b0;
        start_xfer();
        check("t6_restart_busy", {31'b0, busy}, 1);
        check("t6_restart_wcount", {24'b0, wcount}, 0);
        check("t6_restart_last", {31'b0, last}, 0);
        expect_done(cyc + 256, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                check("t6_wcount_1", {24'b0, wcount}, 1);
                check("t6_last_final", {31'b0, last}, 1);
            end
            xfer_ack = 1'b1;
            tick();
        end
        xfer_ack = 1'b0;
        tick();
        check("t6_idle_busy", {31'b0, busy}, 0);

        // Free-run 300 words, abort together with an ack
        clear_irq();
        configure(MODE_FREE, 1'b0, 1'b0, 8'd0, 8'h00, 8'h00);
        start_xfer();
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) check("t5_last", {31'b0, last}, 0);
            xfer_ack = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        xfer_ack = 1'b0;
        abort    = 1'b0;
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_wcount", {24'b0, wcount}, 44);
        check("t5_addr", {24'b0, addr}, 44);
        check("t5_irq", {31'b0, irq}, 0);

        // cfg_we and start together: start uses the old shadows
        cfg_mode = MODE_UP; cfg_dir = 1'b0; cfg_reload = 1'b0;
        cfg_wr = 8'd2; cfg_ac = 8'h80; cfg_alim = 8'h00;
        cfg_we = 1'b1;
        start  = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        check("t7_old_addr", {24'b0, addr}, 0);
        check("t7_busy", {31'b0, busy}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start_xfer();
        check("t7_new_addr", {24'b0, addr}, 32'h80);
        expect_done(cyc + 2, 8'h82, 8'h02);
        xfer_ack = 1'b1;
        tick();
        tick();
        xfer_ack = 1'b0;
        tick();
        tick();
        check("t7_idle_busy", {31'b0, busy}, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_xfer_term.md
# dma_xfer_term

Parametrised transfer-termination unit for the DMA channel. It owns the channel's address counter and word counter and steps both on each word acknowledged by the bus side. It raises a look-ahead `last` flag ahead of the final word, pulses `done` and sets a sticky interrupt when the programmed termination condition is met. Unlike the earlier purely combinational done generator, it is clocked: it holds configuration shadows, supports abort and auto-reload, and is generic in width and address step.

## Interface
Parameters:
- NBITS, 8, width of address, word counter and word register
- ASTEP, 1, address increment/decrement per word (modulo 2^NBITS)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  load configuration shadows; honoured only in IDLE
- cfg_mode  in  2  termination mode (see Operation)
- cfg_dir  in  1  0 = address increments, 1 = decrements
- cfg_reload  in  1  auto-reload enable
- cfg_wr  in  NBITS  word register (length / up-count limit)
- cfg_ac  in  NBITS  start address
- cfg_alim  in  NBITS  address limit for mode 10
- start  in  1  begin transfer; honoured only in IDLE
- xfer_ack  in  1  one word transferred this cycle; ignored outside RUN
- abort  in  1  cancel transfer
- irq_clr  in  1  clear sticky irq
- busy  out  1  state != IDLE
- addr  out  NBITS  current address counter
- wcount  out  NBITS  current word counter
- last  out  1  combinational: in RUN and the next acked word is the final one
- done  out  1  one-cycle pulse, registered
- irq  out  1  sticky, set by done

## Operation
- States: IDLE, RUN, TERM.
- IDLE: on start, load addr <= cfg_ac shadow and wcount <= mode initial value, then enter RUN.
- RUN: on xfer_ack, addr <= addr ± ASTEP and wcount steps. If that ack was the final word, enter TERM.
- TERM: done=1 for exactly this cycle; irq <= 1. Next state is RUN with counters reloaded if cfg_reload, otherwise IDLE.
- Modes (final word = ack while last=1):
  - 00 count-down: wcount init = WR, decrements; last = (wcount == 1). WR=0 means 2^NBITS words (wrap 0 -> all-ones).
  - 01 count-up: wcount init = 0, increments; last = (wcount+1 == WR) at NBITS width. WR=0 means 2^NBITS words.
  - 10 address match: wcount init = 0, increments; last = (addr == ALIM).
  - 11 free-run: last never asserts and done never pulses. wcount and addr wrap; only abort ends the transfer.
- Abort in RUN or TERM: next state IDLE, no done, irq unchanged, counters hold. Abort beats a coincident xfer_ack; that ack is not counted.
- irq: set wins over a same-cycle irq_clr.
- cfg_we and start in the same IDLE cycle: the new config is written and the start uses the old shadows.
- Shadows persist across transfers; auto-reload uses the current shadows.

## Timing
- Reset: state IDLE; addr, wcount, shadows = 0; busy, done, irq = 0; last = 0.
- start at cycle T: busy=1 and addr=cfg_ac from T+1; first ack accepted at T+1.
- Final ack at cycle N: done=1 at N+1. busy=0 at N+2, or stays 1 with reload, in which case counters are reinitialised at N+2 and acks are accepted from N+2.
- xfer_ack during TERM: ignored.
- Throughput: one word per cycle; back-to-back acks allowed.
- Reset mid-transfer: immediate return to reset values on the next edge, no done.

## Structure
- Package dma_term_pkg holds:
  - mode constants MODE_DOWN=2'b00, MODE_UP=2'b01, MODE_ADDR=2'b10, MODE_FREE=2'b11
  - state encoding
  - the NBITS default
- Sub-module dma_term_cmp: combinational last-word detector taking mode, wcount, WR, addr and ALIM and producing last. It is parameterised on NBITS.
- Top level: FSM, counters, shadows, irq.

## Test plan
- Mode 00, WR=3, ac=0x10, dir=0, acks every cycle -> addr 0x10,0x11,0x12; last on third ack; done once at N+1; addr=0x13; busy drops at N+2.
- Mode 01, WR=0 with NBITS=8 -> 256 acks before done; wcount wraps 0xFF->0x00 at the final ack.
- Mode 10, ac=0xFE, alim=0x01, dir=0 -> addr wraps through 0xFF,0x00; done after the ack at 0x01 (4 words).
- Mode 00, WR=4, reload=1 -> two consecutive done pulses 5 cycles apart with continuous acks; busy never drops; irq_clr asserted on the second done cycle leaves irq=1.
- Mode 11 run 300 acks then abort together with an ack -> no done, irq=0, wcount reflects 300 mod 256 = 44; busy=0 next cycle.
- Mode 01 WR=5, rst asserted after 2 acks -> all outputs zero next cycle; a subsequent start uses zeroed shadows (WR=0, i.e. 256-word length).
